// File: rtl/vx_warp_ctl_issue.sv
// Warp-control issue: turns TMC/WSPAWN/BAR requests into one-cycle wctl pulses and tracks barrier arrivals.
// Accept-to-pulse 1 cycle (wspawn waits for a lone active warp); req_ready only in IDLE, one request in flight.
module vx_warp_ctl_issue #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int PC_BITS      = 30,
  localparam int NW_WIDTH    = (NUM_WARPS > 2) ? $clog2(NUM_WARPS) : 1,
  localparam int NB_WIDTH    = (NUM_BARRIERS > 2) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [1:0]                       req_op,
  input  logic [NW_WIDTH-1:0]              req_wid,
  input  logic [NUM_WARPS-1:0]             req_mask,
  input  logic [PC_BITS-1:0]               req_pc,
  input  logic [NB_WIDTH-1:0]              req_bar_id,
  input  logic [NW_WIDTH-1:0]              req_bar_size_m1,
  input  logic [NUM_WARPS-1:0]             active_warps,
  input  logic                             bar_release,
  input  logic [NB_WIDTH-1:0]              bar_release_id,
  output logic                             wctl_valid,
  output logic [NW_WIDTH-1:0]              wctl_wid,
  output logic                             wctl_tmc_valid,
  output logic [NUM_WARPS-1:0]             wctl_tmc_mask,
  output logic                             wctl_wspawn_valid,
  output logic [NUM_WARPS-1:0]             wctl_wspawn_mask,
  output logic [PC_BITS-1:0]               wctl_wspawn_pc,
  output logic                             wctl_bar_valid,
  output logic [NB_WIDTH-1:0]              wctl_bar_id,
  output logic [NW_WIDTH-1:0]              wctl_bar_size_m1,
  output logic [NUM_BARRIERS*NW_WIDTH-1:0] bar_arrived,
  output logic                             err_dup_arrival,
  output logic                             err_op
);

  typedef enum logic [1:0] {IDLE, ISSUE, SPAWN_WAIT, SPAWN_ACK} state_e;

  localparam logic [1:0] OP_TMC    = 2'd0;
  localparam logic [1:0] OP_WSPAWN = 2'd1;
  localparam logic [1:0] OP_BAR    = 2'd2;

  state_e                state_q;
  logic [1:0]            h_op_q;
  logic [NW_WIDTH-1:0]   h_wid_q;
  logic [NUM_WARPS-1:0]  h_mask_q;
  logic [PC_BITS-1:0]    h_pc_q;
  logic [NB_WIDTH-1:0]   h_bar_id_q;
  logic [NW_WIDTH-1:0]   h_bar_sz_q;
  logic [NUM_WARPS-1:0]  act_snap_q;

  logic                  wctl_valid_q;
  logic [NW_WIDTH-1:0]   wctl_wid_q;
  logic                  wctl_tmc_valid_q;
  logic [NUM_WARPS-1:0]  wctl_tmc_mask_q;
  logic                  wctl_ws_valid_q;
  logic [NUM_WARPS-1:0]  wctl_ws_mask_q;
  logic [PC_BITS-1:0]    wctl_ws_pc_q;
  logic                  wctl_bar_valid_q;
  logic [NB_WIDTH-1:0]   wctl_bar_id_q;
  logic [NW_WIDTH-1:0]   wctl_bar_sz_q;
  logic                  err_op_q;
  logic                  err_dup_q;

  logic [NW_WIDTH-1:0]   bar_cnt_q  [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]   bar_cnt_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]  bar_wait_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]  bar_wait_d [NUM_BARRIERS];
  logic                  dup_hit;

  function automatic logic [NW_WIDTH:0] popcnt(input logic [NUM_WARPS-1:0] v);
    logic [NW_WIDTH:0] n;
    n = '0;
    for (int i = 0; i < NUM_WARPS; i++) n = n + {{NW_WIDTH{1'b0}}, v[i]};
    return n;
  endfunction

  assign req_ready = (state_q == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      h_op_q           <= '0;
      h_wid_q          <= '0;
      h_mask_q         <= '0;
      h_pc_q           <= '0;
      h_bar_id_q       <= '0;
      h_bar_sz_q       <= '0;
      act_snap_q       <= '0;
      wctl_valid_q     <= 1'b0;
      wctl_wid_q       <= '0;
      wctl_tmc_valid_q <= 1'b0;
      wctl_tmc_mask_q  <= '0;
      wctl_ws_valid_q  <= 1'b0;
      wctl_ws_mask_q   <= '0;
      wctl_ws_pc_q     <= '0;
      wctl_bar_valid_q <= 1'b0;
      wctl_bar_id_q    <= '0;
      wctl_bar_sz_q    <= '0;
      err_op_q         <= 1'b0;
    end else begin
      // Every wctl field is a one-cycle pulse; zero unless set below.
      wctl_valid_q     <= 1'b0;
      wctl_wid_q       <= '0;
      wctl_tmc_valid_q <= 1'b0;
      wctl_tmc_mask_q  <= '0;
      wctl_ws_valid_q  <= 1'b0;
      wctl_ws_mask_q   <= '0;
      wctl_ws_pc_q     <= '0;
      wctl_bar_valid_q <= 1'b0;
      wctl_bar_id_q    <= '0;
      wctl_bar_sz_q    <= '0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            h_op_q     <= req_op;
            h_wid_q    <= req_wid;
            h_mask_q   <= req_mask;
            h_pc_q     <= req_pc;
            h_bar_id_q <= req_bar_id;
            h_bar_sz_q <= req_bar_size_m1;
            case (req_op)
              OP_TMC: begin
                state_q          <= ISSUE;
                wctl_valid_q     <= 1'b1;
                wctl_wid_q       <= req_wid;
                wctl_tmc_valid_q <= 1'b1;
                wctl_tmc_mask_q  <= req_mask;
              end
              OP_BAR: begin
                state_q          <= ISSUE;
                wctl_valid_q     <= 1'b1;
                wctl_wid_q       <= req_wid;
                wctl_bar_valid_q <= 1'b1;
                wctl_bar_id_q    <= req_bar_id;
                wctl_bar_sz_q    <= req_bar_size_m1;
              end
              OP_WSPAWN: state_q <= SPAWN_WAIT;
              default:   err_op_q <= 1'b1;
            endcase
          end
        end
        ISSUE: state_q <= IDLE;
        SPAWN_WAIT: begin
          if (popcnt(active_warps) == (NW_WIDTH+1)'(1)) begin
            state_q         <= SPAWN_ACK;
            act_snap_q      <= active_warps;
            wctl_valid_q    <= 1'b1;
            wctl_wid_q      <= h_wid_q;
            wctl_ws_valid_q <= 1'b1;
            wctl_ws_mask_q  <= h_mask_q & ~(NUM_WARPS'(1) << h_wid_q);
            wctl_ws_pc_q    <= h_pc_q;
          end
        end
        SPAWN_ACK: begin
          // Hold off new requests until the scheduler shows the spawn took effect.
          if (active_warps != act_snap_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Release is applied before a same-cycle arrival on the same barrier.
  always_comb begin
    bar_cnt_d  = bar_cnt_q;
    bar_wait_d = bar_wait_q;
    dup_hit    = 1'b0;
    if (bar_release) begin
      bar_cnt_d[bar_release_id]  = '0;
      bar_wait_d[bar_release_id] = '0;
    end
    if (state_q == ISSUE && h_op_q == OP_BAR) begin
      if (bar_wait_d[h_bar_id_q][h_wid_q]) begin
        dup_hit = 1'b1;
      end else begin
        bar_wait_d[h_bar_id_q][h_wid_q] = 1'b1;
        bar_cnt_d[h_bar_id_q] = (bar_cnt_d[h_bar_id_q] == h_bar_sz_q) ? '0
                              : bar_cnt_d[h_bar_id_q] + NW_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_cnt_q  <= '{default: '0};
      bar_wait_q <= '{default: '0};
      err_dup_q  <= 1'b0;
    end else begin
      bar_cnt_q  <= bar_cnt_d;
      bar_wait_q <= bar_wait_d;
      err_dup_q  <= err_dup_q | dup_hit;
    end
  end

  always_comb begin
    bar_arrived = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) bar_arrived[b*NW_WIDTH +: NW_WIDTH] = bar_cnt_q[b];
  end

  assign wctl_valid        = wctl_valid_q;
  assign wctl_wid          = wctl_wid_q;
  assign wctl_tmc_valid    = wctl_tmc_valid_q;
  assign wctl_tmc_mask     = wctl_tmc_mask_q;
  assign wctl_wspawn_valid = wctl_ws_valid_q;
  assign wctl_wspawn_mask  = wctl_ws_mask_q;
  assign wctl_wspawn_pc    = wctl_ws_pc_q;
  assign wctl_bar_valid    = wctl_bar_valid_q;
  assign wctl_bar_id       = wctl_bar_id_q;
  assign wctl_bar_size_m1  = wctl_bar_sz_q;
  assign err_dup_arrival   = err_dup_q;
  assign err_op            = err_op_q;

endmodule

// File: doc/vx_warp_ctl_issue.md
VX_WARP_CTL_ISSUE -- requirements
Module: VX_warp_ctl_issue

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of hardware warps (power of two, >=2); NW_WIDTH = max(1, clog2(NUM_WARPS)).
REQ-002 SHALL have parameter NUM_BARRIERS, default 8, number of barrier IDs; NB_WIDTH = max(1, clog2(NUM_BARRIERS)).
REQ-003 SHALL have parameter PC_BITS, default 30, warp PC width.
REQ-004 SHALL have ports: clk in 1, single clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have request ports from execute: req_valid in 1; req_ready out 1; req_op in 2 (0=TMC, 1=WSPAWN, 2=BAR, 3=reserved); req_wid in NW_WIDTH; req_mask in NUM_WARPS (TMC thread mask / WSPAWN warp mask); req_pc in PC_BITS (WSPAWN start PC); req_bar_id in NB_WIDTH; req_bar_size_m1 in NW_WIDTH (participating warps minus one).
REQ-006 SHALL have scheduler-status inputs: active_warps in NUM_WARPS; bar_release in 1 (pulse, barrier drained); bar_release_id in NB_WIDTH.
REQ-007 SHALL have warp-control master outputs: wctl_valid out 1; wctl_wid out NW_WIDTH; wctl_tmc_valid out 1; wctl_tmc_mask out NUM_WARPS; wctl_wspawn_valid out 1; wctl_wspawn_mask out NUM_WARPS; wctl_wspawn_pc out PC_BITS; wctl_bar_valid out 1; wctl_bar_id out NB_WIDTH; wctl_bar_size_m1 out NW_WIDTH.
REQ-008 SHALL have status outputs: bar_arrived out NUM_BARRIERS*NW_WIDTH (per-barrier arrival count, barrier b at bits [b*NW_WIDTH +: NW_WIDTH]); err_dup_arrival out 1 (sticky); err_op out 1 (sticky).

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, SPAWN_WAIT, SPAWN_ACK.
REQ-010 SHALL assert req_ready only in IDLE; a request is accepted when req_valid & req_ready, all req_* fields captured into a holding register that cycle.
REQ-011 IDLE -> ISSUE on accepting TMC or BAR; IDLE -> SPAWN_WAIT on accepting WSPAWN; reserved op: remain IDLE, set err_op, no wctl output.
REQ-012 In ISSUE SHALL drive wctl_valid=1 for exactly one cycle with the held fields, exactly one sub-valid matching the op, then return to IDLE; minimum accept-to-wctl_valid latency = 1 cycle.
REQ-013 In SPAWN_WAIT SHALL issue the wspawn (one-cycle wctl_valid & wctl_wspawn_valid) only in a cycle where popcount(active_warps)==1, then go to SPAWN_ACK; otherwise hold with no output.
REQ-014 In SPAWN_ACK SHALL hold (req_ready=0) until active_warps differs from its value sampled at wspawn issue, then return to IDLE; no second wspawn is issued before the scheduler reflects the first.
REQ-015 wctl_wspawn_mask SHALL equal req_mask with bit req_wid forced to 0.
REQ-016 SHALL keep per-barrier arrival counters and a per-barrier NUM_WARPS-bit waiting mask; on BAR issue, increment bar_arrived[id] and set waiting[id][wid].
REQ-017 When an issued BAR brings the count to bar_size_m1+1 (last arrival), counter for that id SHALL wrap to 0 in the same update; waiting mask SHALL remain until bar_release.
REQ-018 bar_release SHALL clear waiting[bar_release_id] and counter[bar_release_id] next cycle.
REQ-019 A BAR whose warp already has waiting[id][wid]=1 SHALL still be issued but SHALL NOT increment the counter and SHALL set err_dup_arrival.
REQ-020 bar_release and BAR issue on the same id in the same cycle: release clears first, then the arrival applies (counter=1, only new wid bit set).
REQ-021 bar_size_m1==0 BAR SHALL issue with counter staying 0 (immediate single-warp barrier).
REQ-022 All wctl_* data outputs SHALL be 0 whenever wctl_valid=0.

Reset
REQ-023 On reset_n low, asynchronously: FSM=IDLE, req_ready=1 after deassert, all wctl_* =0, all counters and waiting masks =0, err_dup_arrival=0, err_op=0.
REQ-024 Reset mid-operation (any state) SHALL abandon the held request with no wctl pulse after reset deassertion.

Verification
REQ-025 TMC wid=2 mask=4'b0011 -> one cycle later wctl_valid=1, wctl_tmc_valid=1, wctl_wid=2, mask 4'b0011 for exactly one cycle; req_ready low that cycle.
REQ-026 WSPAWN mask=4'b1111 wid=0 pc=0x100 with active_warps=4'b0011 -> no output; active_warps->4'b0001 -> wspawn pulse, mask 4'b1110, pc 0x100; req_ready stays 0 until active_warps->4'b1111.
REQ-027 BAR id=3 size_m1=3 from wids 0,1,2,3 -> counts 1,2,3,0; bar_release id=3 -> waiting[3]=0.
REQ-028 BAR id=1 from wid 2 twice -> count stays 1, err_dup_arrival=1 and sticky.
REQ-029 Same-cycle bar_release id=5 and BAR id=5 wid=0 issue -> counter[5]=1, waiting[5]=4'b0001.
REQ-030 reset_n low while in SPAWN_WAIT -> all outputs 0 immediately; after release no wspawn pulse, req_ready=1.
